// File: rtl/param_pkg.sv
// param_pkg: shared types and constants for the parameter registry loader.
package param_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam int MASK_W = 11;
  localparam int CODE_W = 11;
  localparam int SJW_W = 2;
  localparam int NUM_BYTES = 4;
  localparam logic PID_MASK = 1'b1;
  localparam logic PID_CODE = 1'b0;
endpackage

// File: rtl/param_frame_pack.sv
// param_frame_pack: maps a byte index of the config frame to registry select and data byte.
module param_frame_pack
  import param_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  input  logic [CODE_W-1:0] code,
  input  logic [SJW_W-1:0]  sjw,
  input  logic [1:0]        idx,
  output logic              pid,
  output logic [7:0]        data
);
  always_comb begin
    pid = idx[1] ? PID_CODE : PID_MASK;
    data = (idx == 2'd0) ? mask[7:0] :
           (idx == 2'd1) ? {sjw, 3'b000, mask[10:8]} :
           (idx == 2'd2) ? code[7:0] : {5'b00000, code[10:8]};
  end
endmodule

// File: rtl/param_load_ctrl.sv
// param_load_ctrl: serialises a mask/code/SJW filter configuration into the registry's byte load port.
module param_load_ctrl
  import param_pkg::*;
#(
  parameter int                HOLD_CYCLES = 10,
  parameter bit                BOOT_LOAD   = 1'b1,
  parameter logic [MASK_W-1:0] DEF_MASK    = 11'h7FF,
  parameter logic [CODE_W-1:0] DEF_CODE    = 11'h000,
  parameter logic [SJW_W-1:0]  DEF_SJW     = 2'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MASK_W-1:0] cfg_mask,
  input  logic [CODE_W-1:0] cfg_code,
  input  logic [SJW_W-1:0]  cfg_sjw,
  output logic              param_id,
  output logic [7:0]        param_data,
  output logic              param_we,
  output logic              busy,
  output logic              done
);
  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);
  state_t state_q, state_d;
  logic boot_q, boot_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [SJW_W-1:0] sjw_q, sjw_d;
  logic pid_n;
  logic [7:0] byte_n;
  logic id_q, id_d, we_q, we_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic [7:0] data_q, data_d;
  // boot_q marks the reset-time LOAD whose first byte strobe fires on the first enabled edge
  always_comb begin
    state_d = state_q;
    boot_d = 1'b0;
    idx_d = idx_q;
    cnt_d = cnt_q;
    mask_d = mask_q;
    code_d = code_q;
    sjw_d = sjw_q;
    if (state_q == IDLE && cfg_valid) begin
      state_d = LOAD;
      idx_d = 2'd0;
      cnt_d = 8'd0;
      mask_d = cfg_mask;
      code_d = cfg_code;
      sjw_d = cfg_sjw;
    end else if (state_q == LOAD && !boot_q) begin
      cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
      idx_d = (cnt_q == LAST) ? idx_q + 2'd1 : idx_q;
      state_d = (cnt_q == LAST && idx_q == 2'(NUM_BYTES - 1)) ? DONE : LOAD;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  param_frame_pack u_pack (
    .mask(mask_d),
    .code(code_d),
    .sjw (sjw_d),
    .idx (idx_d),
    .pid (pid_n),
    .data(byte_n)
  );
  always_comb begin
    id_d = (state_d == LOAD) ? pid_n : PID_MASK;
    data_d = (state_d == LOAD) ? byte_n : 8'h00;
    we_d = (state_d == LOAD) && (cnt_d == 8'd0);
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT_LOAD ? LOAD : IDLE;
      boot_q <= BOOT_LOAD;
      idx_q <= 2'd0;
      cnt_q <= 8'd0;
      mask_q <= DEF_MASK;
      code_q <= DEF_CODE;
      sjw_q <= DEF_SJW;
      id_q <= PID_MASK;
      data_q <= BOOT_LOAD ? DEF_MASK[7:0] : 8'h00;
      we_q <= 1'b0;
      busy_q <= BOOT_LOAD;
      done_q <= 1'b0;
      ready_q <= !BOOT_LOAD;
    end else begin
      state_q <= state_d;
      boot_q <= boot_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      code_q <= code_d;
      sjw_q <= sjw_d;
      id_q <= id_d;
      data_q <= data_d;
      we_q <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ready_q <= ready_d;
    end
  end
  assign param_id = id_q;
  assign param_data = data_q;
  assign param_we = we_q;
  assign busy = busy_q;
  assign done = done_q;
  assign cfg_ready = ready_q;
endmodule

// File: doc/param_load_ctrl.md
# param_load_ctrl

Sequencer that configures the parameter registry: it takes a complete acceptance-filter configuration (11-bit mask, 11-bit code, 2-bit SJW) and serialises it into the registry's byte-wide load port. It drives `param_id` and the 8-bit data bus with a fixed byte order and hold time. After reset it loads a default configuration automatically. It sits between the host/config interface and the registry, and is the registry's only writer.

## Interface
- `HOLD_CYCLES`, 10: clock cycles each byte is held on the bus; legal range 1..255.
- `BOOT_LOAD`, 1: 1 = load the default configuration automatically after reset; 0 = come out of reset idle.
- `DEF_MASK`, 11'h7FF: default mask used by the boot load.
- `DEF_CODE`, 11'h000: default code used by the boot load.
- `DEF_SJW`, 2'd1: default SJW used by the boot load.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  host request; configuration fields are valid.
- `cfg_ready`  out  1  controller is idle and accepts a request.
- `cfg_mask`  in  11  requested mask.
- `cfg_code`  in  11  requested code.
- `cfg_sjw`  in  2  requested SJW.
- `param_id`  out  1  registry select: 1 = mask/SJW bytes, 0 = code bytes.
- `param_data`  out  8  registry data byte.
- `param_we`  out  1  high on the first cycle of each byte.
- `busy`  out  1  high while a load is in progress, including the DONE cycle.
- `done`  out  1  one-cycle pulse when a load completes.

## Operation
- A request is accepted on a rising edge where `cfg_valid && cfg_ready`. All three fields are captured into shadow registers at that edge, so the host may change them afterwards.
- Byte frame, sent in this order:
  - B0 = `mask[7:0]` with `param_id`=1.
  - B1 = `{sjw[1:0], 3'b000, mask[10:8]}` with `param_id`=1.
  - B2 = `code[7:0]` with `param_id`=0.
  - B3 = `{5'b00000, code[10:8]}` with `param_id`=0.
- Each byte is held for exactly `HOLD_CYCLES` cycles. `param_we` is high only in the first of those cycles.
- States:
  - IDLE: `cfg_ready`=1.
  - LOAD: 2-bit byte index plus hold counter.
  - DONE: lasts 1 cycle, then returns to IDLE.
- Transitions:
  - IDLE→LOAD on acceptance.
  - LOAD advances the byte index when the hold counter reaches `HOLD_CYCLES-1`.
  - LOAD→DONE after the last cycle of B3.
  - DONE→IDLE unconditionally.
- `cfg_valid` outside IDLE is ignored; nothing is queued. A requester must keep `cfg_valid` high until it sees `cfg_ready`.
- Boot load (`BOOT_LOAD`=1):
  - Reset state is a LOAD of B0 using the DEF_* values.
  - It takes priority over any `cfg_valid` present at reset release.
  - It raises `done` exactly like a host load.
- In IDLE: `param_id`=1, `param_data`=8'h00, `param_we`=0.
- Reset asserted mid-load aborts the load immediately (asynchronously). No `done` is produced. The registry contents are then undefined until the next complete load.

## Timing
- Reset values:
  - `param_id`=1, `param_we`=0, `done`=0.
  - `BOOT_LOAD`=1: `param_data`=`DEF_MASK[7:0]`, `busy`=1, `cfg_ready`=0, with B0's `param_we` issued on the first cycle after reset release (first enabled cycle).
  - `BOOT_LOAD`=0: `param_data`=8'h00, `busy`=0, `cfg_ready`=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Host load accepted at edge N:
  - B0 appears in cycle N+1.
  - Byte k occupies cycles N+1+k·H .. N+(k+1)·H, where H = `HOLD_CYCLES`.
  - `done`=1 in cycle N+4H+1.
  - `cfg_ready`=1 from cycle N+4H+2.
- Load duration is 4H+1 cycles with `busy` high; the minimum request-to-request spacing is 4H+2 cycles.
- `HOLD_CYCLES`=1: one byte per cycle, and `param_we` is high for 4 consecutive cycles.

## Structure
- Shared package `param_pkg` holds:
  - the state enum (IDLE, LOAD, DONE);
  - localparams `MASK_W`=11, `CODE_W`=11, `SJW_W`=2, `NUM_BYTES`=4;
  - the `param_id` encodings `PID_MASK`=1 and `PID_CODE`=0.
- One sub-module, `param_frame_pack`: combinational; maps (mask, code, sjw, byte index) to (`param_id`, data byte).
- The FSM, hold counter and shadow registers live in the top module.

## Test plan
- Boot with `BOOT_LOAD`=1, defaults, H=10, reset released at 20 ns → B0=8'hFF (id=1), B1=8'h47 (id=1), B2=8'h00 (id=0), B3=8'h00 (id=0), each for 10 cycles; `done` pulses once; `cfg_ready` rises the cycle after.
- Host load mask=11'h5AA, code=11'h30F, sjw=2 while idle → B0=8'hAA, B1=8'h85, B2=8'h0F, B3=8'h03; `done` in cycle N+41.
- `cfg_valid` held high with new values while busy → no acceptance until `cfg_ready`; the second load carries the values present at its own acceptance edge; the first load is unchanged.
- Reset asserted during B2 → `param_id`=1, `param_we`=0 and no `done` immediately; after release the boot load restarts from B0.
- H=1, `BOOT_LOAD`=0, back-to-back requests → `param_we` high for 4 consecutive cycles; `done` at N+5; second acceptance no earlier than N+6.
- `cfg_valid` asserted in the same cycle reset releases with `BOOT_LOAD`=1 → the boot frame (defaults) is sent first; the host request is accepted after its `done`.
